// File: rtl/decode_stage.sv
// Purpose: ID stage - 8x16 register file with write-through reads, opcode decode into MEM/EX/WB bundles, immediate and flush.
// Latency: reads and decode are combinational (0 cycles); write-back commits on the rising clock edge.
// Backpressure: none; the stage never stalls, and a two-word LDM raises o_flush to squash the next fetched word.
module decode_stage #(
    parameter int WIDTH = 16,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic [AW-1:0]    i_src,
    input  logic [AW-1:0]    i_dst,
    input  logic [3:0]       i_shiftamount,
    input  logic             i_regwrite,
    input  logic [WIDTH-1:0] i_wd,
    input  logic [AW-1:0]    i_wa,
    output logic [WIDTH-1:0] o_rsrc,
    output logic [WIDTH-1:0] o_rdst,
    output logic [WIDTH-1:0] o_imm,
    output logic [3:0]       o_mem_signals,
    output logic [5:0]       o_ex_signals,
    output logic [2:0]       o_wb_signals,
    output logic             o_flush
);

    // Register file storage
    logic [WIDTH-1:0] r_regs [REGS];

    // Combinational read and decode results, before the reset gate
    logic [WIDTH-1:0] w_rsrc;
    logic [WIDTH-1:0] w_rdst;
    logic [3:0]       w_mem;
    logic             w_alu_en;
    logic [3:0]       w_alu_op;
    logic             w_shamt_sel;
    logic [2:0]       w_wb;
    logic             w_flush;

    // Write-back port: async clear, then one register written per rising edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_regwrite) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Operand reads; a same-cycle write to the addressed register bypasses the array
    always_comb begin
        w_rsrc = r_regs[i_src];
        w_rdst = r_regs[i_dst];
        if (i_regwrite && (i_wa == i_src)) begin
            w_rsrc = i_wd;
        end
        if (i_regwrite && (i_wa == i_dst)) begin
            w_rdst = i_wd;
        end
    end

    // Opcode decode; anything not listed falls through as a NOP with all controls low
    always_comb begin
        w_mem       = 4'b0000;
        w_alu_en    = 1'b0;
        w_alu_op    = 4'b0000;
        w_shamt_sel = 1'b0;
        w_wb        = 3'b000;
        w_flush     = 1'b0;
        case (i_opcode)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8: begin
                // NOT INC DEC MOV ADD SUB AND OR: ALU result written back
                w_alu_en = 1'b1;
                w_alu_op = i_opcode[3:0];
                w_wb     = 3'b100;
            end
            6'd9, 6'd10: begin
                // SHL SHR: ALU op taking the shift amount from the immediate
                w_alu_en    = 1'b1;
                w_alu_op    = i_opcode[3:0];
                w_shamt_sel = 1'b1;
                w_wb        = 3'b100;
            end
            6'd11: begin
                // LDM: immediate written back, second instruction word squashed
                w_wb    = 3'b110;
                w_flush = 1'b1;
            end
            6'd12: begin
                // LDD
                w_mem = 4'b1010;
                w_wb  = 3'b101;
            end
            6'd13: begin
                // STD
                w_mem = 4'b0110;
            end
            6'd14: begin
                // PUSH
                w_mem = 4'b0101;
            end
            6'd15: begin
                // POP
                w_mem = 4'b1000;
                w_wb  = 3'b101;
            end
            default: begin
                w_mem = 4'b0000;
            end
        endcase
    end

    // Every output is held at zero while reset is asserted
    assign o_rsrc        = i_rst ? '0 : w_rsrc;
    assign o_rdst        = i_rst ? '0 : w_rdst;
    assign o_imm         = i_rst ? '0 : {{(WIDTH-4){1'b0}}, i_shiftamount};
    assign o_mem_signals = i_rst ? 4'b0000 : w_mem;
    assign o_ex_signals  = i_rst ? 6'b000000 : {w_alu_en, w_alu_op, w_shamt_sel};
    assign o_wb_signals  = i_rst ? 3'b000 : w_wb;
    assign o_flush       = i_rst ? 1'b0 : w_flush;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
module tb_decode_stage;

    typedef struct {
        logic [15:0] rsrc;
        logic [15:0] rdst;
        logic [15:0] imm;
        logic [3:0]  mem;
        logic [5:0]  ex;
        logic [2:0]  wb;
        logic        flush;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic [2:0]  src = '0;
    logic [2:0]  dst = '0;
    logic [3:0]  shamt = '0;
    logic        we = 1'b0;
    logic [15:0] wd = '0;
    logic [2:0]  wa = '0;
    logic [15:0] rsrc, rdst, imm;
    logic [3:0]  mem_s;
    logic [5:0]  ex_s;
    logic [2:0]  wb_s;
    logic        flush;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    decode_stage dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_src(src), .i_dst(dst),
        .i_shiftamount(shamt), .i_regwrite(we), .i_wd(wd), .i_wa(wa),
        .o_rsrc(rsrc), .o_rdst(rdst), .o_imm(imm), .o_mem_signals(mem_s),
        .o_ex_signals(ex_s), .o_wb_signals(wb_s), .o_flush(flush)
    );

    // 20 ns period: negedge at 20k, posedge at 20k+10
    always #10 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    endtask

    task automatic drv(input logic r, input logic [5:0] op, input logic [2:0] s, input logic [2:0] d,
                       input logic [3:0] sh, input logic w, input logic [15:0] wdat, input logic [2:0] waddr);
        rst = r; opcode = op; src = s; dst = d; shamt = sh; we = w; wd = wdat; wa = waddr;
    endtask

    task automatic expect_out(input string name, input logic [15:0] es, input logic [15:0] ed, input logic [15:0] ei,
                              input logic [3:0] em, input logic [5:0] ee, input logic [2:0] ew, input logic ef);
        exp_t e;
        e.rsrc = es; e.rdst = ed; e.imm = ei; e.mem = em; e.ex = ee; e.wb = ew; e.flush = ef; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: samples four times between negedge and the next posedge, popping one expectation per sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                #2;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(e.name, "rsrc",  rsrc,  e.rsrc);
                    chk(e.name, "rdst",  rdst,  e.rdst);
                    chk(e.name, "imm",   imm,   e.imm);
                    chk(e.name, "mem",   {12'b0, mem_s}, {12'b0, e.mem});
                    chk(e.name, "ex",    {10'b0, ex_s},  {10'b0, e.ex});
                    chk(e.name, "wb",    {13'b0, wb_s},  {13'b0, e.wb});
                    chk(e.name, "flush", {15'b0, flush}, {15'b0, e.flush});
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Stimulus: directed vectors with hand-computed expectations
    initial begin
        // Reset held: outputs zero regardless of inputs
        @(negedge clk); drv(1, 6'b000101, 3'd1, 3'd2, 4'hF, 1, 16'hAAAA, 3'd1);
        expect_out("rst_add", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        @(negedge clk); drv(1, 6'b001011, 3'd7, 3'd7, 4'h9, 1, 16'h5A5A, 3'd7);
        expect_out("rst_ldm", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        // After release every register reads zero
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drv(0, 6'b000000, 3'(2*i), 3'(2*i+1), 4'h0, 0, 16'h0, 3'd0);
            expect_out("post_rst_read", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        end
        // ADD with write-through on src: R0 <= FFFF
        @(negedge clk); drv(0, 6'b000101, 3'd0, 3'd1, 4'h0, 1, 16'hFFFF, 3'd0);
        expect_out("add_wt", 16'hFFFF, 16'h0000, 16'h0000, 4'h0, 6'b101010, 3'b100, 0);
        // SHL: stored R0, write-through R1 <= 1234
        @(negedge clk); drv(0, 6'b001001, 3'd0, 3'd1, 4'h5, 1, 16'h1234, 3'd1);
        expect_out("shl", 16'hFFFF, 16'h1234, 16'h0005, 4'h0, 6'b110011, 3'b100, 0);
        // LDM
        @(negedge clk); drv(0, 6'b001011, 3'd1, 3'd0, 4'h3, 0, 16'h0, 3'd0);
        expect_out("ldm", 16'h1234, 16'hFFFF, 16'h0003, 4'h0, 6'b000000, 3'b110, 1);
        // STD, R7 <= 7777 in the background
        @(negedge clk); drv(0, 6'b001101, 3'd2, 3'd3, 4'h0, 1, 16'h7777, 3'd7);
        expect_out("std", 16'h0, 16'h0, 16'h0, 4'b0110, 6'b000000, 3'b000, 0);
        // POP with R7 written and read on both ports in one cycle
        @(negedge clk); drv(0, 6'b001111, 3'd7, 3'd7, 4'h0, 1, 16'h8888, 3'd7);
        expect_out("pop_r7_wt", 16'h8888, 16'h8888, 16'h0, 4'b1000, 6'b000000, 3'b101, 0);
        // Unlisted opcode behaves as NOP
        @(negedge clk); drv(0, 6'b111111, 3'd7, 3'd0, 4'h9, 0, 16'h0, 3'd0);
        expect_out("op_3f", 16'h8888, 16'hFFFF, 16'h0009, 4'h0, 6'b000000, 3'b000, 0);
        // LDD
        @(negedge clk); drv(0, 6'b001100, 3'd1, 3'd7, 4'h0, 0, 16'h0, 3'd0);
        expect_out("ldd", 16'h1234, 16'h8888, 16'h0, 4'b1010, 6'b000000, 3'b101, 0);
        // PUSH, R2 <= 2222
        @(negedge clk); drv(0, 6'b001110, 3'd0, 3'd1, 4'h0, 1, 16'h2222, 3'd2);
        expect_out("push", 16'hFFFF, 16'h1234, 16'h0, 4'b0101, 6'b000000, 3'b000, 0);
        // SHR with write-through on dst, R3 <= 3333
        @(negedge clk); drv(0, 6'b001010, 3'd2, 3'd3, 4'hF, 1, 16'h3333, 3'd3);
        expect_out("shr_wt", 16'h2222, 16'h3333, 16'h000F, 4'h0, 6'b110101, 3'b100, 0);
        // NOT
        @(negedge clk); drv(0, 6'b000001, 3'd3, 3'd2, 4'h0, 0, 16'h0, 3'd0);
        expect_out("not", 16'h3333, 16'h2222, 16'h0, 4'h0, 6'b100010, 3'b100, 0);
        // OR, R4 <= 4444
        @(negedge clk); drv(0, 6'b001000, 3'd4, 3'd5, 4'h0, 1, 16'h4444, 3'd4);
        expect_out("or", 16'h4444, 16'h0, 16'h0, 4'h0, 6'b110000, 3'b100, 0);
        // Fill R5 and R6
        @(negedge clk); drv(0, 6'b000000, 3'd5, 3'd6, 4'h0, 1, 16'h5555, 3'd5);
        expect_out("fill_r5", 16'h5555, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        @(negedge clk); drv(0, 6'b000000, 3'd6, 3'd5, 4'h0, 1, 16'h6666, 3'd6);
        expect_out("fill_r6", 16'h6666, 16'h5555, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        // Write to R6 in flight, then reset lands before the edge: write aborted
        @(negedge clk); drv(0, 6'b000101, 3'd6, 3'd5, 4'h0, 1, 16'hABCD, 3'd6);
        expect_out("pre_abort", 16'hABCD, 16'h5555, 16'h0, 4'h0, 6'b101010, 3'b100, 0);
        #3; rst = 1'b1;
        expect_out("abort_in_rst", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        @(negedge clk); drv(0, 6'b000000, 3'd6, 3'd5, 4'h0, 0, 16'h0, 3'd0);
        expect_out("abort_r6", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        // Refill, then a reset pulse entirely between two edges clears the file
        @(negedge clk); drv(0, 6'b000000, 3'd1, 3'd7, 4'h0, 1, 16'hBEEF, 3'd1);
        expect_out("refill_r1", 16'hBEEF, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        @(negedge clk); drv(0, 6'b000000, 3'd1, 3'd0, 4'h0, 0, 16'h0, 3'd0);
        expect_out("r1_stored", 16'hBEEF, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        #3; rst = 1'b1;
        expect_out("pulse_rst", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        #2; rst = 1'b0;
        expect_out("pulse_r1_cleared", 16'h0, 16'h0, 16'h0, 4'h0, 6'h00, 3'b000, 0);
        // Let the monitor drain, then confirm nothing is left unchecked
        repeat (2) @(negedge clk);
        #9;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
